fc_16_10_seq: RTL and testbench
===============================

Name: fc_16_10_seq

Overview:
- Final classifier stage. Sits directly downstream of the 64→16 fully-connected layer.
- Its start_flag is driven by the upstream end_flag. Its in bus is driven by the upstream 160-bit out bus.
- Computes 10 output neurons from 16 activations using a single time-multiplexed MAC, with weights streamed from an external synchronous ROM.
- Produces saturated 16-bit scores and the argmax class index.

Parameters:
- N_IN, 16, input lanes.
- N_OUT, 10, output neurons.
- IN_W, 10, input lane width (unsigned).
- W_W, 8, weight/bias width (signed two's complement).
- OUT_W, 16, output score width (signed, saturated).
- ACC_W, 24, accumulator width (signed).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start_flag  in  1  one-cycle pulse; input vector valid
- in  in  160  16×10-bit unsigned activations; lane 0 = in[159:150], lane 15 = in[9:0]
- rom_en  out  1  ROM read enable
- rom_addr  out  8  ROM address; neuron i, term j at i*17+j; j=16 is bias
- rom_data  in  8  signed weight/bias, valid the cycle after rom_en
- out  out  160  10×16-bit signed scores; neuron 0 = out[159:144]
- class_out  out  4  index of max score
- end_flag  out  1  one-cycle completion pulse
- busy  out  1  high from the cycle after an accepted start until end_flag

Behaviour:
- Clock is clk. Reset is reset, synchronous, active-high. Reset values:
  - out=0, class_out=0, end_flag=0, busy=0, rom_en=0, rom_addr=0.
  - FSM=IDLE, accumulator=0, counters=0.
- FSM states: IDLE → FETCH → DRAIN → FINAL → DONE → IDLE.
- IDLE:
  - start_flag=1 at edge T: latch in into a 160-bit register; i=0, j=0; go FETCH.
  - start_flag while not IDLE is ignored. No queueing.
- FETCH: rom_en=1, rom_addr=i*17+j, one address per cycle, addresses 0..169 in cycles T+1..T+170.
  - j wraps 16→0 with i+1.
  - After address 169, go DRAIN.
- MAC stage (one cycle behind fetch), for the returned rom_data:
  - j<16: acc += {0,in_lane[j]} × sext(rom_data). 19-bit signed product, sign-extended to ACC_W.
  - j=16: acc += sext(rom_data) (bias, unscaled). Then register the neuron result and clear acc for the next neuron.
  - No overflow is possible in ACC_W: |sum| ≤ 16×1023×128+128.
- Score saturation: score = acc clamped to [-32768, 32767].
- Score storage: written into its out lane slot via a shadow register. Visible out changes only at DONE.
- Argmax:
  - Updated as each score is produced.
  - Strict greater-than, so ties keep the lower index.
  - Neuron 0 initialises the running max.
- DRAIN: waits for the last MAC. FINAL: saturation and argmax of neuron 9.
- DONE:
  - Copy shadow scores to out and the index to class_out.
  - end_flag=1 for exactly one cycle, at cycle T+173 (LAT = N_OUT*(N_IN+1)+3).
  - Return to IDLE.
  - A start_flag sampled in the DONE cycle is ignored.
- busy is high T+1 through T+173 inclusive.
- out and class_out hold their values until the next DONE.
- Reset mid-operation: abort immediately. All outputs return to reset values, including clearing a previously held out.
- rom_en is 0 in every state except FETCH.

Test Plan:
- All weights 1, biases 0, all lanes 1023, start at T → end_flag exactly at T+173. Every score 16368 (0x3FF0). class_out=0 (tie rule).
- All weights 127, biases 127, all lanes 1023 → raw 2078863. Every score saturates to 32767 (0x7FFF). class_out=0.
- All weights -128, biases -128, all lanes 1023 → raw -2095232. Every score -32768 (0x8000).
- Lanes = j+1. Neuron 7 weights 2, all others weights 1, biases 0 → neuron 7 score 272, others 136, class_out=7.
- rom_addr trace check: the sequence must be 0,1,…,169 on consecutive cycles with rom_en high only during FETCH.
- Second start_flag at T+50 is ignored, with end_flag still at T+173 and results unchanged. Reset asserted at T+80 → outputs zero, busy=0, no end_flag. A new start then completes normally 173 cycles later.

Source files
------------

// File: rtl/fc_16_10_seq_if.sv
// Bus bundle between the 64->16 layer, the weight ROM and the final classifier.
// The slave modport is the classifier; the master modport is the surrounding environment.
interface fc_16_10_seq_if;
    logic               start_flag;
    logic [159:0]       in;
    logic               rom_en;
    logic [7:0]         rom_addr;
    logic signed [7:0]  rom_data;
    logic [159:0]       out;
    logic [3:0]         class_out;
    logic               end_flag;
    logic               busy;

    modport slave (
        input  start_flag, in, rom_data,
        output rom_en, rom_addr, out, class_out, end_flag, busy
    );

    modport master (
        output start_flag, in, rom_data,
        input  rom_en, rom_addr, out, class_out, end_flag, busy
    );
endinterface

// File: rtl/fc_16_10_seq.sv
// 16->10 fully-connected classifier: one time-multiplexed MAC fed by a synchronous weight ROM,
// saturated 16-bit scores and argmax index published together with a one-cycle end_flag.
module fc_16_10_seq (
    input  logic              clk,
    input  logic              reset,
    fc_16_10_seq_if.slave     bus
);
    localparam int N_IN  = 16;
    localparam int N_OUT = 10;
    localparam int IN_W  = 10;
    localparam int W_W   = 8;
    localparam int OUT_W = 16;
    localparam int ACC_W = 24;
    localparam int P_W   = IN_W + W_W + 1;

    localparam logic signed [ACC_W-1:0] SAT_HI = 24'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_LO = -24'sd32768;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DRAIN, S_FINAL, S_DONE} state_t;

    state_t r_state, w_state_next;
    logic   w_rom_en, w_busy, w_end_flag;

    logic [3:0]  r_i;
    logic [4:0]  r_j;
    logic [7:0]  r_addr;
    logic [IN_W-1:0] r_lane [N_IN];

    logic        r_mac_vld;
    logic [4:0]  r_mac_j;
    logic [3:0]  r_mac_i;
    logic signed [ACC_W-1:0] r_acc, r_res;
    logic        r_res_vld;
    logic [3:0]  r_res_idx;

    logic signed [OUT_W-1:0] r_shadow [N_OUT];
    logic signed [OUT_W-1:0] w_shadow_next [N_OUT];
    logic signed [OUT_W-1:0] r_max, w_max_next;
    logic [3:0]  r_idx, w_idx_next;
    logic [159:0] r_out, w_out_packed;
    logic [3:0]  r_class;

    logic               w_last_fetch, w_start_ok;
    logic [IN_W-1:0]    w_lane;
    logic signed [W_W-1:0]   w_rom;
    logic signed [P_W-1:0]   w_a, w_b, w_prod;
    logic signed [ACC_W-1:0] w_term, w_sum;
    logic signed [OUT_W-1:0] w_sat;

    assign w_last_fetch = (r_i == 4'(N_OUT - 1)) && (r_j == 5'(N_IN));
    assign w_start_ok   = (r_state == S_IDLE) && bus.start_flag;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_rom_en     = 1'b0;
        w_busy       = 1'b1;
        w_end_flag   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start_flag) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                w_rom_en = 1'b1;
                if (w_last_fetch) w_state_next = S_DRAIN;
            end
            S_DRAIN: w_state_next = S_FINAL;
            S_FINAL: w_state_next = S_DONE;
            S_DONE: begin
                w_end_flag   = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Address generator walks neuron-major, 17 terms per neuron, bias last.
    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_i    <= '0;
            r_j    <= '0;
            r_addr <= '0;
        end else if (r_state == S_FETCH) begin
            r_addr <= r_addr + 8'd1;
            if (r_j == 5'(N_IN)) begin
                r_j <= '0;
                r_i <= r_i + 4'd1;
            end else begin
                r_j <= r_j + 5'd1;
            end
        end
    end

    for (genvar gi = 0; gi < N_IN; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (reset)           r_lane[gi] <= '0;
            else if (w_start_ok) r_lane[gi] <= bus.in[159-IN_W*gi -: IN_W];
        end
    end

    // MAC runs one cycle behind fetch so it lines up with the ROM read latency.
    assign w_lane = r_lane[r_mac_j[3:0]];
    assign w_rom  = $signed(bus.rom_data);
    assign w_a    = $signed({{(P_W-IN_W){1'b0}}, w_lane});
    assign w_b    = $signed({{(P_W-W_W){w_rom[W_W-1]}}, w_rom});
    assign w_prod = w_a * w_b;
    assign w_term = (r_mac_j == 5'(N_IN)) ? {{(ACC_W-W_W){w_rom[W_W-1]}}, w_rom}
                                          : {{(ACC_W-P_W){w_prod[P_W-1]}}, w_prod};
    assign w_sum  = r_acc + w_term;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mac_vld <= 1'b0;
            r_mac_j   <= '0;
            r_mac_i   <= '0;
            r_acc     <= '0;
            r_res     <= '0;
            r_res_vld <= 1'b0;
            r_res_idx <= '0;
        end else begin
            r_mac_vld <= (r_state == S_FETCH);
            r_mac_j   <= r_j;
            r_mac_i   <= r_i;
            r_res_vld <= 1'b0;
            if (r_mac_vld) begin
                if (r_mac_j == 5'(N_IN)) begin
                    r_res     <= w_sum;
                    r_res_vld <= 1'b1;
                    r_res_idx <= r_mac_i;
                    r_acc     <= '0;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    assign w_sat = (r_res > SAT_HI) ? 16'sh7FFF :
                   (r_res < SAT_LO) ? 16'sh8000 : r_res[OUT_W-1:0];

    always_comb begin
        w_shadow_next = r_shadow;
        w_max_next    = r_max;
        w_idx_next    = r_idx;
        if (r_res_vld) begin
            w_shadow_next[r_res_idx] = w_sat;
            // Strict compare keeps the lower index on ties; neuron 0 seeds the max.
            if ((r_res_idx == 4'd0) || (w_sat > r_max)) begin
                w_max_next = w_sat;
                w_idx_next = r_res_idx;
            end
        end
    end

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_pack
        assign w_out_packed[159-OUT_W*gi -: OUT_W] = w_shadow_next[gi];
    end

    // Publishing on the FINAL->DONE edge makes out/class_out valid alongside end_flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N_OUT; k++) r_shadow[k] <= '0;
            r_max   <= '0;
            r_idx   <= '0;
            r_out   <= '0;
            r_class <= '0;
        end else begin
            r_shadow <= w_shadow_next;
            r_max    <= w_max_next;
            r_idx    <= w_idx_next;
            if (r_state == S_FINAL) begin
                r_out   <= w_out_packed;
                r_class <= w_idx_next;
            end
        end
    end

    assign bus.rom_en    = w_rom_en;
    assign bus.rom_addr  = w_rom_en ? r_addr : 8'd0;
    assign bus.busy      = w_busy;
    assign bus.end_flag  = w_end_flag;
    assign bus.out       = r_out;
    assign bus.class_out = r_class;
endmodule

// File: tb/tb_fc_16_10_seq.sv
// Self-checking bench for fc_16_10_seq: directed and random vectors against an arithmetic
// reference model, cycle-exact timing of rom_en/rom_addr/busy/end_flag, restart and reset cases.
module tb_fc_16_10_seq;
    logic clk;
    logic reset;

    fc_16_10_seq_if bus();

    fc_16_10_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0] rom [170];
    int                lanes [16];
    int                n_vec  = 0;
    int                n_fail = 0;

    always @(posedge clk) begin
        if (reset)           bus.rom_data <= 8'sd0;
        else if (bus.rom_en) bus.rom_data <= rom[bus.rom_addr];
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] pack_lanes();
        logic [159:0] p;
        p = '0;
        for (int j = 0; j < 16; j++) p[159-10*j -: 10] = 10'(lanes[j]);
        return p;
    endfunction

    // Reference: dot product plus bias, clamp to 16 bits, first-maximum argmax.
    function automatic void model(output logic [159:0] o, output logic [3:0] c);
        int s, best, best_v;
        o = '0;
        best = 0;
        best_v = 0;
        for (int i = 0; i < 10; i++) begin
            s = int'(rom[i*17+16]);
            for (int j = 0; j < 16; j++) s += lanes[j] * int'(rom[i*17+j]);
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            o[159-16*i -: 16] = 16'(s);
            if (i == 0 || s > best_v) begin
                best_v = s;
                best   = i;
            end
        end
        c = 4'(best);
    endfunction

    task automatic set_uniform(input int lane_v, input int w, input int b);
        for (int j = 0; j < 16; j++) lanes[j] = lane_v;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 16; j++) rom[i*17+j] = 8'(w);
            rom[i*17+16] = 8'(b);
        end
    endtask

    // restart_at: cycle after start to pulse start_flag again (0 = never).
    // reset_at:   cycle after start to assert reset and abort (0 = never).
    task automatic run_txn(input string name, input int restart_at, input int reset_at);
        logic [159:0] exp_out;
        logic [3:0]   exp_cls;
        logic         saw_end;
        model(exp_out, exp_cls);
        @(negedge clk);
        bus.in         = pack_lanes();
        bus.start_flag = 1'b1;
        @(posedge clk);
        #1;
        bus.start_flag = 1'b0;
        for (int k = 1; k <= 174; k++) begin
            if (k == reset_at) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                chk({name, "_rst_out"},   bus.out, 160'd0);
                chk({name, "_rst_class"}, 160'(bus.class_out), 160'd0);
                chk({name, "_rst_busy"},  160'(bus.busy), 160'd0);
                chk({name, "_rst_end"},   160'(bus.end_flag), 160'd0);
                chk({name, "_rst_romen"}, 160'(bus.rom_en), 160'd0);
                saw_end = 1'b0;
                repeat (200) begin
                    @(posedge clk);
                    #1;
                    if (bus.end_flag) saw_end = 1'b1;
                end
                chk({name, "_no_end_after_rst"}, 160'(saw_end), 160'd0);
                $display("txn %s: aborted by reset at T+%0d", name, k);
                return;
            end
            chk($sformatf("%s_busy_T%0d", name, k),  160'(bus.busy),     160'(k <= 173));
            chk($sformatf("%s_end_T%0d", name, k),   160'(bus.end_flag), 160'(k == 173));
            chk($sformatf("%s_romen_T%0d", name, k), 160'(bus.rom_en),   160'(k <= 170));
            if (k <= 170)
                chk($sformatf("%s_addr_T%0d", name, k), 160'(bus.rom_addr), 160'(k - 1));
            if (k >= 173) begin
                chk($sformatf("%s_out_T%0d", name, k),   bus.out, exp_out);
                chk($sformatf("%s_class_T%0d", name, k), 160'(bus.class_out), 160'(exp_cls));
            end
            if (k == restart_at) begin
                bus.start_flag = 1'b1;
                bus.in         = ~bus.in;
            end
            @(posedge clk);
            #1;
            bus.start_flag = 1'b0;
        end
        $display("txn %s: out=%h class=%0d", name, bus.out, bus.class_out);
    endtask

    initial begin
        logic [159:0] held;
        reset          = 1'b1;
        bus.start_flag = 1'b0;
        bus.in         = '0;
        set_uniform(0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out",   bus.out, 160'd0);
        chk("reset_class", 160'(bus.class_out), 160'd0);
        chk("reset_end",   160'(bus.end_flag), 160'd0);
        chk("reset_busy",  160'(bus.busy), 160'd0);
        chk("reset_romen", 160'(bus.rom_en), 160'd0);
        chk("reset_addr",  160'(bus.rom_addr), 160'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        set_uniform(1023, 1, 0);
        run_txn("ones", 0, 0);
        chk("ones_lane0_const", 160'(bus.out[159:144]), 160'h3FF0);
        chk("ones_lane9_const", 160'(bus.out[15:0]),    160'h3FF0);

        set_uniform(1023, 127, 127);
        run_txn("sat_hi", 0, 0);
        chk("sat_hi_const", 160'(bus.out[95:80]), 160'h7FFF);

        set_uniform(1023, -128, -128);
        run_txn("sat_lo", 0, 0);
        chk("sat_lo_const", 160'(bus.out[63:48]), 160'h8000);

        set_uniform(0, 1, 0);
        for (int j = 0; j < 16; j++) lanes[j] = j + 1;
        for (int j = 0; j < 16; j++) rom[7*17+j] = 8'sd2;
        run_txn("n7", 0, 0);
        chk("n7_score_const",  160'(bus.out[47:32]),   160'd272);
        chk("n7_other_const",  160'(bus.out[159:144]), 160'd136);
        chk("n7_class_const",  160'(bus.class_out),    160'd7);

        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 16; j++) lanes[j] = int'($urandom_range(0, 1023));
            for (int a = 0; a < 170; a++) rom[a] = 8'($urandom_range(0, 255));
            if (r == 0)
                for (int a = 0; a < 170; a++) rom[a] = 8'($urandom_range(0, 7)) - 8'sd3;
            run_txn($sformatf("rand%0d", r), 0, 0);
        end

        held = bus.out;
        repeat (10) @(posedge clk);
        #1;
        chk("hold_after_done", bus.out, held);

        set_uniform(0, 1, 0);
        for (int j = 0; j < 16; j++) lanes[j] = int'($urandom_range(0, 1023));
        for (int a = 0; a < 170; a++) rom[a] = 8'($urandom_range(0, 255));
        run_txn("restart50", 50, 0);
        run_txn("start_in_done", 173, 0);

        run_txn("abort80", 0, 80);

        for (int j = 0; j < 16; j++) lanes[j] = int'($urandom_range(0, 1023));
        run_txn("after_abort", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
